// File: rtl/codec_ctrl_slave_if.sv
// Pin bundle for the codec control-port responder: 3-wire SPI inputs, commit report, register read port.
// SPI_ERR_COUNT_EN adds the err_count status output.
interface codec_ctrl_slave_if;
    logic       spi_sck;
    logic       spi_mosi;
    logic       cs;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       active;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       frame_err;
    logic       addr_err;
`ifdef SPI_ERR_COUNT_EN
    logic [7:0] err_count;

    modport slave (
        input  spi_sck, spi_mosi, cs, rd_addr,
        output wr_strobe, wr_addr, wr_data, active, rd_data, frame_err, addr_err, err_count
    );
    modport master (
        output spi_sck, spi_mosi, cs, rd_addr,
        input  wr_strobe, wr_addr, wr_data, active, rd_data, frame_err, addr_err, err_count
    );
`else
    modport slave (
        input  spi_sck, spi_mosi, cs, rd_addr,
        output wr_strobe, wr_addr, wr_data, active, rd_data, frame_err, addr_err
    );
    modport master (
        output spi_sck, spi_mosi, cs, rd_addr,
        input  wr_strobe, wr_addr, wr_data, active, rd_data, frame_err, addr_err
    );
`endif
endinterface

// File: rtl/codec_ctrl_slave.sv
// 3-wire SPI codec control-port responder: 16-bit {addr,data} frames into a 10-entry register file.
// Optional SPI_ERR_COUNT_EN: saturating count of frame_err/addr_err pulses on err_count.
module codec_ctrl_slave #(
    parameter int unsigned NUM_REGS = 10,
    parameter logic [6:0]  RST_ADDR = 7'h0F
) (
    input  logic             clk,
    input  logic             reset,
    codec_ctrl_slave_if.slave bus
);
    localparam int unsigned ACTIVE_REG = 9;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state;
    logic [2:0]  sck_sync;
    logic [2:0]  cs_sync;
    logic [1:0]  mosi_sync;
    logic        armed;
    logic [4:0]  bit_cnt;
    logic [15:0] shreg;
    logic [8:0]  regs [NUM_REGS];

    logic        sck_rise;
    logic        cs_rise;
    logic        cs_fall;
    logic [6:0]  frame_addr;
    logic [8:0]  frame_data;
    logic [6:0]  partner;
    logic        link_en;
    logic        addr_in_map;

    function automatic logic [8:0] reg_default(int unsigned idx);
        case (idx)
            0, 1:    return 9'h097;
            2, 3:    return 9'h079;
            4:       return 9'h00A;
            5:       return 9'h008;
            6:       return 9'h09F;
            7:       return 9'h00A;
            default: return 9'h000;
        endcase
    endfunction

    // Edges compare the second sync stage against a third; mosi shares the same two-stage delay
    assign sck_rise    = sck_sync[1] & ~sck_sync[2];
    assign cs_rise     = cs_sync[1] & ~cs_sync[2];
    assign cs_fall     = ~cs_sync[1] & cs_sync[2];
    assign frame_addr  = shreg[15:9];
    assign frame_data  = shreg[8:0];
    assign partner     = {frame_addr[6:1], ~frame_addr[0]};
    assign link_en     = frame_data[8] && (frame_addr[6:2] == 5'd0);
    assign addr_in_map = 32'(frame_addr) < NUM_REGS;

    always_comb begin
        bus.rd_data = '0;
        if (32'(bus.rd_addr) < NUM_REGS) bus.rd_data = regs[bus.rd_addr];
        bus.active = regs[ACTIVE_REG][0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            sck_sync      <= '0;
            cs_sync       <= '0;
            mosi_sync     <= '0;
            armed         <= 1'b0;
            bit_cnt       <= '0;
            shreg         <= '0;
            bus.wr_strobe <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.frame_err <= 1'b0;
            bus.addr_err  <= 1'b0;
`ifdef SPI_ERR_COUNT_EN
            bus.err_count <= '0;
`endif
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= reg_default(i);
        end else begin
            sck_sync      <= {sck_sync[1:0], bus.spi_sck};
            cs_sync       <= {cs_sync[1:0], bus.cs};
            mosi_sync     <= {mosi_sync[0], bus.spi_mosi};
            bus.wr_strobe <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.addr_err  <= 1'b0;

            if (cs_sync[1]) armed <= 1'b1;
            if (cs_fall) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end

            case (state)
                IDLE: begin
                    if (cs_fall && armed) state <= SHIFT;
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= COMMIT;
                    end else if (sck_rise) begin
                        shreg <= {shreg[14:0], mosi_sync[1]};
                        if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (bit_cnt != 5'd16) begin
                        bus.frame_err <= 1'b1;
`ifdef SPI_ERR_COUNT_EN
                        if (bus.err_count != '1) bus.err_count <= bus.err_count + 8'd1;
`endif
                    end else if (addr_in_map) begin
                        bus.wr_strobe <= 1'b1;
                        bus.wr_addr   <= frame_addr;
                        bus.wr_data   <= frame_data;
                        // Linked channel pairs (0/1, 2/3) update together when data[8] is set
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (i == 32'(frame_addr) || (link_en && i == 32'(partner)))
                                regs[i] <= frame_data;
                        end
                    end else if (frame_addr == RST_ADDR) begin
                        bus.wr_strobe <= 1'b1;
                        bus.wr_addr   <= frame_addr;
                        bus.wr_data   <= frame_data;
                        if (frame_data == '0) begin
                            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= reg_default(i);
`ifdef SPI_ERR_COUNT_EN
                            bus.err_count <= '0;
`endif
                        end
                    end else begin
                        bus.addr_err <= 1'b1;
`ifdef SPI_ERR_COUNT_EN
                        if (bus.err_count != '1) bus.err_count <= bus.err_count + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
